// File: rtl/traffic_phase_controller.sv
// Phase sequencer for a main/side road intersection with a pedestrian crossing.
// Phases are timed in tick strobes; side-road and pedestrian requests are latched until served.
module traffic_phase_controller #(
    parameter int TW     = 8,
    parameter int T_INIT = 2,
    parameter int T_MG   = 10,
    parameter int T_Y    = 3,
    parameter int T_AR   = 2,
    parameter int T_SG   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [6:0] light_signals,
    output logic [2:0] phase,
    output logic       ped_wait
);

    typedef enum logic [2:0] {
        INIT_RED    = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        CLEAR_1     = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        CLEAR_2     = 3'd6,
        UNUSED_7    = 3'd7
    } state_t;

    localparam logic [TW-1:0] LD_INIT = TW'(T_INIT - 1);
    localparam logic [TW-1:0] LD_MG   = TW'(T_MG - 1);
    localparam logic [TW-1:0] LD_Y    = TW'(T_Y - 1);
    localparam logic [TW-1:0] LD_AR   = TW'(T_AR - 1);
    localparam logic [TW-1:0] LD_SG   = TW'(T_SG - 1);
    localparam logic [6:0]    ALL_RED = 7'b1001000;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          car_pend_q, car_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic          walk_q, walk_d;
    logic [6:0]    light_q, light_d;
    logic          expired;
    logic          enter_sg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_RED;
            timer_q    <= LD_INIT;
            car_pend_q <= 1'b0;
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
            light_q    <= ALL_RED;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            car_pend_q <= car_pend_d;
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
            light_q    <= light_d;
        end
    end

    // MAIN_GREEN parks at timer 0 until a request is pending.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        expired = tick && (timer_q == '0);
        case (state_q)
            INIT_RED:    if (expired) state_d = MAIN_GREEN;
            MAIN_GREEN:  if (expired && (car_pend_q || ped_pend_q)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expired) state_d = CLEAR_1;
            CLEAR_1:     if (expired) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (expired) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (expired) state_d = CLEAR_2;
            CLEAR_2:     if (expired) state_d = MAIN_GREEN;
            default:     state_d = INIT_RED;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                MAIN_GREEN:                timer_d = LD_MG;
                MAIN_YELLOW, SIDE_YELLOW:  timer_d = LD_Y;
                CLEAR_1, CLEAR_2:          timer_d = LD_AR;
                SIDE_GREEN:                timer_d = LD_SG;
                default:                   timer_d = LD_INIT;
            endcase
        end else if (tick && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Entering SIDE_GREEN serves and clears both requests; a request on that same edge is absorbed.
    always_comb begin
        enter_sg   = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);
        car_pend_d = car_pend_q | (side_req && (state_q != SIDE_GREEN));
        ped_pend_d = ped_pend_q | (ped_req && !((state_q == SIDE_GREEN) && walk_q));
        walk_d     = walk_q;
        if (enter_sg) begin
            walk_d     = ped_pend_q;
            car_pend_d = 1'b0;
            ped_pend_d = 1'b0;
        end else if (state_d != SIDE_GREEN) begin
            walk_d = 1'b0;
        end

        case (state_d)
            MAIN_GREEN:  light_d = 7'b0011000;
            MAIN_YELLOW: light_d = 7'b0101000;
            SIDE_GREEN:  light_d = {6'b100001, walk_d};
            SIDE_YELLOW: light_d = 7'b1000100;
            default:     light_d = ALL_RED;
        endcase
    end

    assign light_signals = light_q;
    assign phase         = state_q;
    assign ped_wait      = ped_pend_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a vector table for the main sequences
// plus hand-written tick-gating, mid-walk request and mid-operation reset sequences.
module tb_traffic_phase_controller;

    localparam logic [2:0] P_INIT = 3'd0;
    localparam logic [2:0] P_MG   = 3'd1;
    localparam logic [2:0] P_MY   = 3'd2;
    localparam logic [2:0] P_CL1  = 3'd3;
    localparam logic [2:0] P_SG   = 3'd4;
    localparam logic [2:0] P_SY   = 3'd5;
    localparam logic [2:0] P_CL2  = 3'd6;

    localparam logic [6:0] L_RED = 7'b1001000;
    localparam logic [6:0] L_MG  = 7'b0011000;
    localparam logic [6:0] L_MY  = 7'b0101000;
    localparam logic [6:0] L_SG  = 7'b1000010;
    localparam logic [6:0] L_SGW = 7'b1000011;
    localparam logic [6:0] L_SY  = 7'b1000100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       side_req;
    logic       ped_req;
    logic [6:0] light_signals;
    logic [2:0] phase;
    logic       ped_wait;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       t;
        logic       s;
        logic       p;
        logic [2:0] ph;
        logic [6:0] li;
        logic       w;
    } vec_t;

    vec_t vecs[$];

    traffic_phase_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .side_req     (side_req),
        .ped_req      (ped_req),
        .light_signals(light_signals),
        .phase        (phase),
        .ped_wait     (ped_wait)
    );

    always #5 clk = ~clk;

    function automatic void addVec(string n, logic r, logic t, logic s, logic p,
                                   logic [2:0] ph, logic [6:0] li, logic w);
        vec_t v;
        v.name = n; v.rst = r; v.t = t; v.s = s; v.p = p;
        v.ph = ph; v.li = li; v.w = w;
        vecs.push_back(v);
    endfunction

    function automatic void addRun(string n, int cnt, logic [2:0] ph, logic [6:0] li, logic w);
        for (int i = 0; i < cnt; i++) addVec(n, 1'b0, 1'b1, 1'b0, 1'b0, ph, li, w);
    endfunction

    function automatic logic [6:0] lightOf(logic [2:0] ph);
        case (ph)
            P_MG:    return L_MG;
            P_MY:    return L_MY;
            P_SG:    return L_SG;
            P_SY:    return L_SY;
            default: return L_RED;
        endcase
    endfunction

    // Drive one cycle of inputs, let the rising edge take them, and return at the falling edge.
    task automatic applyStimulus(input logic t, input logic s, input logic p);
        tick = t; side_req = s; ped_req = p;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0; side_req = 1'b0; ped_req = 1'b0;
    endtask

    task automatic checkOutput(input string n, input logic [2:0] eph,
                               input logic [6:0] eli, input logic ew);
        compared++;
        if (phase !== eph || light_signals !== eli || ped_wait !== ew) begin
            mismatched++;
            $display("[TB] FAIL %s: got phase=%0d light=%b wait=%b, want phase=%0d light=%b wait=%b",
                     n, phase, light_signals, ped_wait, eph, eli, ew);
        end
    endtask

    task automatic stepCheck(input string n, input logic t, input logic s, input logic p,
                             input logic [2:0] ph, input logic [6:0] li, input logic w);
        applyStimulus(t, s, p);
        checkOutput(n, ph, li, w);
    endtask

    task automatic runSeq(input string n, input int cnt, input logic [2:0] ph,
                          input logic [6:0] li, input logic w);
        for (int i = 0; i < cnt; i++) stepCheck(n, 1'b1, 1'b0, 1'b0, ph, li, w);
    endtask

    // Assert reset between clock edges so the outputs must change without a clock.
    task automatic doReset(input string n);
        #2 rst_n = 1'b0;
        #1 checkOutput(n, P_INIT, L_RED, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int tgDur[5];
    logic [2:0] tgPh[6];

    initial begin
        rst_n = 1'b1; tick = 1'b0; side_req = 1'b0; ped_req = 1'b0;

        // Idle: INIT_RED for 2 ticks, then MAIN_GREEN held with no requests.
        addVec("idle_init", 1'b1, 1'b1, 1'b0, 1'b0, P_INIT, L_RED, 1'b0);
        addVec("idle_mg_entry", 1'b0, 1'b1, 1'b0, 1'b0, P_MG, L_MG, 1'b0);
        addRun("idle_hold", 200, P_MG, L_MG, 1'b0);

        // Vehicle service from a fresh reset, side_req pulsed on the 3rd cycle of MAIN_GREEN.
        addVec("veh_init", 1'b1, 1'b1, 1'b0, 1'b0, P_INIT, L_RED, 1'b0);
        addVec("veh_mg_entry", 1'b0, 1'b1, 1'b0, 1'b0, P_MG, L_MG, 1'b0);
        for (int j = 1; j <= 9; j++)
            addVec("veh_mg", 1'b0, 1'b1, (j == 3), 1'b0, P_MG, L_MG, 1'b0);
        addRun("veh_my", 3, P_MY, L_MY, 1'b0);
        addRun("veh_cl1", 2, P_CL1, L_RED, 1'b0);
        addRun("veh_sg", 6, P_SG, L_SG, 1'b0);
        addRun("veh_sy", 3, P_SY, L_SY, 1'b0);
        addRun("veh_cl2", 2, P_CL2, L_RED, 1'b0);
        addRun("veh_mg_hold", 13, P_MG, L_MG, 1'b0);

        // Pedestrian request pulsed during MAIN_YELLOW gets a walk phase.
        addVec("ped_side", 1'b0, 1'b1, 1'b1, 1'b0, P_MG, L_MG, 1'b0);
        addVec("ped_my_entry", 1'b0, 1'b1, 1'b0, 1'b0, P_MY, L_MY, 1'b0);
        addVec("ped_pulse_my", 1'b0, 1'b1, 1'b0, 1'b1, P_MY, L_MY, 1'b1);
        addRun("ped_my", 1, P_MY, L_MY, 1'b1);
        addRun("ped_cl1", 2, P_CL1, L_RED, 1'b1);
        addRun("ped_sg_walk", 6, P_SG, L_SGW, 1'b0);
        addRun("ped_sy", 3, P_SY, L_SY, 1'b0);
        addRun("ped_cl2", 2, P_CL2, L_RED, 1'b0);
        addRun("ped_mg_hold", 13, P_MG, L_MG, 1'b0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset({vecs[i].name, "_rst"});
            stepCheck(vecs[i].name, vecs[i].t, vecs[i].s, vecs[i].p,
                      vecs[i].ph, vecs[i].li, vecs[i].w);
        end

        // Tick every 4th cycle: each phase must last 4x its tick count.
        tgDur = '{3, 2, 6, 3, 2};
        tgPh  = '{P_MY, P_CL1, P_SG, P_SY, P_CL2, P_MG};
        stepCheck("tg_req_no_tick", 1'b0, 1'b1, 1'b0, P_MG, L_MG, 1'b0);
        stepCheck("tg_my_entry", 1'b1, 1'b0, 1'b0, P_MY, L_MY, 1'b0);
        for (int p = 0; p < 5; p++) begin
            for (int k = 1; k < 4 * tgDur[p]; k++)
                stepCheck("tg_hold", (k % 4 == 0), 1'b0, 1'b0, tgPh[p], lightOf(tgPh[p]), 1'b0);
            stepCheck("tg_advance", 1'b1, 1'b0, 1'b0, tgPh[p+1], lightOf(tgPh[p+1]), 1'b0);
        end
        runSeq("tg_post_hold", 10, P_MG, L_MG, 1'b0);

        // ped_req during a walk is ignored; MAIN_GREEN then holds.
        stepCheck("mw1_ped", 1'b1, 1'b0, 1'b1, P_MG, L_MG, 1'b1);
        runSeq("mw1_my", 3, P_MY, L_MY, 1'b1);
        runSeq("mw1_cl1", 2, P_CL1, L_RED, 1'b1);
        runSeq("mw1_sg_entry", 1, P_SG, L_SGW, 1'b0);
        stepCheck("mw1_ped_in_walk", 1'b1, 1'b0, 1'b1, P_SG, L_SGW, 1'b0);
        runSeq("mw1_sg", 4, P_SG, L_SGW, 1'b0);
        runSeq("mw1_sy", 3, P_SY, L_SY, 1'b0);
        runSeq("mw1_cl2", 2, P_CL2, L_RED, 1'b0);
        runSeq("mw1_mg_hold", 14, P_MG, L_MG, 1'b0);

        // ped_req during a no-walk SIDE_GREEN is latched and served next cycle with walk.
        stepCheck("mw0_side", 1'b1, 1'b1, 1'b0, P_MG, L_MG, 1'b0);
        runSeq("mw0_my", 3, P_MY, L_MY, 1'b0);
        runSeq("mw0_cl1", 2, P_CL1, L_RED, 1'b0);
        runSeq("mw0_sg_entry", 1, P_SG, L_SG, 1'b0);
        stepCheck("mw0_ped_in_sg", 1'b1, 1'b0, 1'b1, P_SG, L_SG, 1'b1);
        runSeq("mw0_sg", 4, P_SG, L_SG, 1'b1);
        runSeq("mw0_sy", 3, P_SY, L_SY, 1'b1);
        runSeq("mw0_cl2", 2, P_CL2, L_RED, 1'b1);
        runSeq("mw0_mg", 10, P_MG, L_MG, 1'b1);
        runSeq("mw0_my2", 3, P_MY, L_MY, 1'b1);
        runSeq("mw0_cl1b", 2, P_CL1, L_RED, 1'b1);
        runSeq("mw0_sg_walk", 3, P_SG, L_SGW, 1'b0);

        // Reset in the middle of a walk phase restarts at INIT_RED.
        doReset("rst_in_walk");
        runSeq("rst1_init", 1, P_INIT, L_RED, 1'b0);
        runSeq("rst1_mg_hold", 14, P_MG, L_MG, 1'b0);

        // Reset with a pedestrian request pending must drop it.
        stepCheck("rst2_ped", 1'b1, 1'b0, 1'b1, P_MG, L_MG, 1'b1);
        runSeq("rst2_my", 1, P_MY, L_MY, 1'b1);
        doReset("rst_with_pend");
        runSeq("rst2_init", 1, P_INIT, L_RED, 1'b0);
        runSeq("rst2_mg_hold", 14, P_MG, L_MG, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
